// File: rtl/seven_segments_decoder.sv
// Recovers the 0..99 value from a two-digit active-low 7-segment bus once the pattern pair
// has been stable for STABLE_CYCLES clocks; invalid glyphs raise o_Error and bump a saturating count.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_SETTLING | pair changed recently; waiting for the stability window
// ST_LOCKED   | current pair already committed; no further commits until it changes
module seven_segments_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [6:0] i_Segment1,
    input  logic [6:0] i_Segment2,
    output logic [6:0] o_Value,
    output logic       o_Valid,
    output logic       o_Error,
    output logic [7:0] o_Err_Count
);

    typedef enum logic {
        ST_SETTLING = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    // Stability timer counts down the remaining matching edges; zero means the window is complete.
    localparam logic [7:0] TMR_LOAD = 8'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [6:0] seg1_q, seg1_d;
    logic [6:0] seg2_q, seg2_d;
    logic [7:0] tmr_q, tmr_d;
    logic [6:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       pair_match;
    logic       commit;
    logic [4:0] tens_dec;
    logic [4:0] units_dec;
    logic [6:0] tens_ext;
    logic [6:0] units_ext;
    logic [6:0] value_sum;

    // Returns {valid, digit}; anything outside the ten glyphs (blank included) is invalid.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = {1'b1, 4'd0};
            7'b1111001: res = {1'b1, 4'd1};
            7'b0100100: res = {1'b1, 4'd2};
            7'b0110000: res = {1'b1, 4'd3};
            7'b0011001: res = {1'b1, 4'd4};
            7'b0010010: res = {1'b1, 4'd5};
            7'b0000010: res = {1'b1, 4'd6};
            7'b1111000: res = {1'b1, 4'd7};
            7'b0000000: res = {1'b1, 4'd8};
            7'b0010000: res = {1'b1, 4'd9};
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    always_comb begin
        // Decode only the sampled pair; a commit requires input == sample, so both views agree.
        tens_dec   = decode_glyph(seg1_q);
        units_dec  = decode_glyph(seg2_q);
        tens_ext   = {3'b000, tens_dec[3:0]};
        units_ext  = {3'b000, units_dec[3:0]};
        value_sum  = (tens_ext << 3) + (tens_ext << 1) + units_ext;

        pair_match = (i_Segment1 == seg1_q) && (i_Segment2 == seg2_q);

        seg1_d     = i_Segment1;
        seg2_d     = i_Segment2;
        tmr_d      = tmr_q;
        state_d    = state_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        error_d    = error_q;
        err_cnt_d  = err_cnt_q;
        commit     = 1'b0;

        if (!pair_match) begin
            tmr_d   = TMR_LOAD;
            state_d = ST_SETTLING;
        end else begin
            if (tmr_q != 8'd0) begin
                tmr_d = tmr_q - 8'd1;
            end
            if (state_q == ST_SETTLING && tmr_q == 8'd0) begin
                commit  = 1'b1;
                state_d = ST_LOCKED;
            end
        end

        if (commit) begin
            if (tens_dec[4] && units_dec[4]) begin
                value_d = value_sum;
                error_d = 1'b0;
                valid_d = 1'b1;
            end else begin
                error_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_SETTLING;
            seg1_q    <= 7'h7F;
            seg2_q    <= 7'h7F;
            tmr_q     <= TMR_LOAD;
            value_q   <= 7'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
            tmr_q     <= tmr_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_Value     = value_q;
    assign o_Valid     = valid_q;
    assign o_Error     = error_q;
    assign o_Err_Count = err_cnt_q;

endmodule

// File: tb/tb_seven_segments_decoder.sv
// Directed bench for seven_segments_decoder with STABLE_CYCLES = 4: commit latency, single pulse,
// glitch recovery, invalid glyphs, error-count saturation and mid-window reset.
module tb_seven_segments_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic [6:0] o_Value;
    logic       o_Valid;
    logic       o_Error;
    logic [7:0] o_Err_Count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] G [10];
    logic [6:0] BLANK;
    logic [6:0] BAD1;

    seven_segments_decoder #(.STABLE_CYCLES(4)) dut (
        .i_Clk       (clk),
        .i_Rst_n     (rst_n),
        .i_Segment1  (seg1),
        .i_Segment2  (seg2),
        .o_Value     (o_Value),
        .o_Valid     (o_Valid),
        .o_Error     (o_Error),
        .o_Err_Count (o_Err_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        seg1  = BLANK;
        seg2  = BLANK;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (o_Value !== 7'd0) begin n_fail++; $display("FAIL reset_value got=%0d exp=0", o_Value); end
        n_checks++;
        if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_Valid); end
        n_checks++;
        if (o_Error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", o_Error); end
        n_checks++;
        if (o_Err_Count !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got=%0d exp=0", o_Err_Count); end
        #2;
        rst_n = 1'b1;
        seg1  = G[0];
        seg2  = G[0];
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL zero_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
            if (e == 5) begin
                n_checks++;
                if (o_Value !== 7'd0) begin n_fail++; $display("FAIL zero_value got=%0d exp=0", o_Value); end
                n_checks++;
                if (o_Error !== 1'b0) begin n_fail++; $display("FAIL zero_error got=%b exp=0", o_Error); end
            end
        end
    endtask

    task automatic test_hold_42();
        int pulses = 0;
        seg1 = G[4];
        seg2 = G[2];
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (o_Valid === 1'b1) pulses++;
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL hold42_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
        end
        n_checks++;
        if (o_Value !== 7'd42) begin n_fail++; $display("FAIL hold42_value got=%0d exp=42", o_Value); end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL hold42_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_glitch_99();
        int pulses = 0;
        seg1 = G[9]; seg2 = G[9];
        repeat (3) begin tick(); if (o_Valid === 1'b1) pulses++; end
        seg1 = G[5]; seg2 = G[7];
        repeat (3) begin tick(); if (o_Valid === 1'b1) pulses++; end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL glitch_early_pulses got=%0d exp=0", pulses); end
        n_checks++;
        if (o_Value !== 7'd42) begin n_fail++; $display("FAIL glitch_hold_value got=%0d exp=42", o_Value); end
        seg1 = G[9]; seg2 = G[9];
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL glitch99_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
        end
        n_checks++;
        if (o_Value !== 7'd99) begin n_fail++; $display("FAIL glitch99_value got=%0d exp=99", o_Value); end
    endtask

    task automatic test_invalid_then_12();
        seg1 = G[9];
        seg2 = BLANK;
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL blank_valid edge=%0d got=%b exp=0", e, o_Valid); end
            n_checks++;
            if (o_Error !== (e >= 5)) begin
                n_fail++; $display("FAIL blank_error edge=%0d got=%b exp=%b", e, o_Error, (e >= 5));
            end
        end
        n_checks++;
        if (o_Err_Count !== 8'd1) begin n_fail++; $display("FAIL blank_errcnt got=%0d exp=1", o_Err_Count); end
        n_checks++;
        if (o_Value !== 7'd99) begin n_fail++; $display("FAIL blank_value got=%0d exp=99", o_Value); end
        seg1 = G[1];
        seg2 = G[2];
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL v12_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
            n_checks++;
            if (o_Error !== (e < 5)) begin
                n_fail++; $display("FAIL v12_error edge=%0d got=%b exp=%b", e, o_Error, (e < 5));
            end
        end
        n_checks++;
        if (o_Value !== 7'd12) begin n_fail++; $display("FAIL v12_value got=%0d exp=12", o_Value); end
        n_checks++;
        if (o_Err_Count !== 8'd1) begin n_fail++; $display("FAIL v12_errcnt got=%0d exp=1", o_Err_Count); end
    endtask

    task automatic test_err_saturation();
        int pulses = 0;
        seg1 = G[0];
        for (int i = 1; i <= 300; i++) begin
            seg2 = (i % 2 == 1) ? BLANK : BAD1;
            repeat (5) begin tick(); if (o_Valid === 1'b1) pulses++; end
            if (i == 100 || i == 253 || i == 254) begin
                n_checks++;
                if (o_Err_Count !== 8'(1 + i)) begin
                    n_fail++; $display("FAIL sat_errcnt iter=%0d got=%0d exp=%0d", i, o_Err_Count, 1 + i);
                end
            end
        end
        n_checks++;
        if (o_Err_Count !== 8'd255) begin n_fail++; $display("FAIL sat_final got=%0d exp=255", o_Err_Count); end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=0", pulses); end
        n_checks++;
        if (o_Error !== 1'b1) begin n_fail++; $display("FAIL sat_error got=%b exp=1", o_Error); end
        n_checks++;
        if (o_Value !== 7'd12) begin n_fail++; $display("FAIL sat_value got=%0d exp=12", o_Value); end
    endtask

    task automatic test_reset_mid();
        seg1 = G[6];
        seg2 = G[3];
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_Err_Count !== 8'd0) begin n_fail++; $display("FAIL midrst_errcnt got=%0d exp=0", o_Err_Count); end
        n_checks++;
        if (o_Error !== 1'b0) begin n_fail++; $display("FAIL midrst_error got=%b exp=0", o_Error); end
        n_checks++;
        if (o_Value !== 7'd0) begin n_fail++; $display("FAIL midrst_value got=%0d exp=0", o_Value); end
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL midrst_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
        end
        n_checks++;
        if (o_Value !== 7'd63) begin n_fail++; $display("FAIL midrst_value63 got=%0d exp=63", o_Value); end
    endtask

    task automatic test_back_to_back();
        // 64 held for 4 edges, then the units digit changes right on the would-be commit edge.
        seg1 = G[6];
        seg2 = G[4];
        repeat (4) tick();
        seg2 = G[5];
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL late_change_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
        end
        n_checks++;
        if (o_Value !== 7'd65) begin n_fail++; $display("FAIL late_change_value got=%0d exp=65", o_Value); end
        seg2 = G[6];
        tick();
        seg2 = G[5];
        for (int e = 1; e <= 6; e++) begin
            tick();
            n_checks++;
            if (o_Valid !== (e == 5)) begin
                n_fail++; $display("FAIL represent_valid edge=%0d got=%b exp=%b", e, o_Valid, (e == 5));
            end
        end
        n_checks++;
        if (o_Value !== 7'd65) begin n_fail++; $display("FAIL represent_value got=%0d exp=65", o_Value); end
    endtask

    initial begin
        G[0] = 7'b1000000; G[1] = 7'b1111001; G[2] = 7'b0100100; G[3] = 7'b0110000;
        G[4] = 7'b0011001; G[5] = 7'b0010010; G[6] = 7'b0000010; G[7] = 7'b1111000;
        G[8] = 7'b0000000; G[9] = 7'b0010000;
        BLANK = 7'b1111111;
        BAD1  = 7'b0000001;
        rst_n = 1'b0;
        seg1  = BLANK;
        seg2  = BLANK;

        test_reset();
        test_hold_42();
        test_glitch_99();
        test_invalid_then_12();
        test_err_saturation();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
